mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter peripheral for the Starfish MCU. It is the responder on the core's data-memory store/load path and the outbound end of the MCU's serial console. It accepts bytes written by the core into a small FIFO and serializes them 8N1 on a single `tx` line. Bench and board logic receive program output from this line.

---
 rtl/mmio_uart_tx.sv | 257 +++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, byte FIFO and an 8N1 serializer.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [TW-1:0] TIMER_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef MMIO_UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef MMIO_UART_TX_PARITY_EN
    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic [31:0]   rdata_q;
`ifdef MMIO_UART_TX_PARITY_EN
    logic          parity_q;
`endif

    logic          sel_data_s;
    logic          sel_status_s;
    logic          push_req_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic          wrap_s;
    logic          ovf_clr_s;
    logic          idle_next_s;
    logic [7:0]    head_s;
    logic [31:0]   status_s;
    logic          unused_wdata_s;

    assign unused_wdata_s = ^bus_wdata[31:8];

    // Address decode, FIFO flags and pop/push qualification.
    always_comb begin
        sel_data_s   = (bus_addr == BASE_ADDR);
        sel_status_s = (bus_addr == STATUS_ADDR);
        full_s       = (count_q == COUNT_FULL);
        empty_s      = (count_q == CW'(0));
        push_req_s   = bus_we && sel_data_s;
        push_s       = push_req_s && !full_s;
        ovf_clr_s    = bus_we && sel_status_s && bus_wdata[3];
        wrap_s       = (timer_q == TIMER_LAST);
        head_s       = fifo_q[rd_ptr_q];
        // The FSM only takes a byte while idle or on the final stop-bit cycle.
        pop_s        = !empty_s && ((state_q == S_IDLE) || ((state_q == S_STOP) && wrap_s));
        idle_next_s  = !pop_s && ((state_q == S_IDLE) || ((state_q == S_STOP) && wrap_s));
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // STATUS word assembly.
    always_comb begin
        status_s    = 32'd0;
        status_s[0] = full_s;
        status_s[1] = empty_s;
        status_s[2] = busy_q;
        status_s[3] = overflow_q;
        if (32'(count_q) > 32'd15) begin
            status_s[7:4] = 4'hF;
        end else begin
            status_s[7:4] = 4'(count_q);
        end
`ifdef MMIO_UART_TX_PARITY_EN
        status_s[8] = 1'b1;
`else
        status_s[8] = 1'b0;
`endif
    end

    // FIFO storage; flushing is done through the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= bus_wdata[7:0];
        end
    end

    // FIFO pointers, count and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= PW'(0);
            rd_ptr_q   <= PW'(0);
            count_q    <= CW'(0);
            overflow_q <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            if (push_req_s && full_s) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Serializer FSM with registered line and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= TW'(0);
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            busy_q <= !idle_next_s || (count_d != CW'(0));
            case (state_q)
                S_IDLE: begin
                    timer_q <= TW'(0);
                    if (pop_s) begin
                        shift_q <= head_s;
`ifdef MMIO_UART_TX_PARITY_EN
                        parity_q <= parity8(head_s);
`endif
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (wrap_s) begin
                        timer_q   <= TW'(0);
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (wrap_s) begin
                        timer_q <= TW'(0);
                        if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`ifdef MMIO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (wrap_s) begin
                        timer_q <= TW'(0);
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (wrap_s) begin
                        timer_q <= TW'(0);
                        if (pop_s) begin
                            shift_q <= head_s;
`ifdef MMIO_UART_TX_PARITY_EN
                            parity_q <= parity8(head_s);
`endif
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    timer_q <= TW'(0);
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Load data is valid for exactly one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (bus_re && sel_status_s) begin
            rdata_q <= status_s;
        end else begin
            rdata_q <= 32'd0;
        end
    end

    assign bus_rdata = rdata_q;
    assign tx        = tx_q;
    assign tx_busy   = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, serial-line scoreboard
// and hand-written burst, overflow and mid-frame reset sequences.
module tb_mmio_uart_tx;

    localparam int          CPB   = 16;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_FF00;
    localparam logic [31:0] STAT  = BASE + 32'd4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          NB    = 11;
    localparam logic [31:0] PBIT  = 32'h0000_0100;
`else
    localparam int          NB    = 10;
    localparam logic [31:0] PBIT  = 32'h0000_0000;
`endif
    localparam int FRAME = NB * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_addr = 32'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic        tx;
    logic        tx_busy;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
        .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         rst_events = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_cycle(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_we = we; bus_re = re; bus_addr = a; bus_wdata = d;
        @(posedge clk);
        #1;
        bus_we = 1'b0; bus_re = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
        bus_cycle(1'b0, 1'b1, a, 32'd0);
        @(negedge clk);
        r = bus_rdata;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (tx_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: tx_busy still high after %0d cycles", n);
        end
    endtask

    // Line monitor: decodes each frame at bit centers and scores it against exp_q.
    initial begin : monitor
        logic          tx_prev;
        logic [NB-1:0] bits;
        logic [7:0]    want;
        int            rst_mark;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && tx_prev === 1'b1 && tx === 1'b0) begin
                starts.push_back(cyc);
                rst_mark = rst_events;
                for (int k = 0; k < NB; k++) begin
                    for (int j = 0; j < ((k == 0) ? CPB / 2 : CPB); j++) @(negedge clk);
                    bits[k] = tx;
                end
                if (rst_mark == rst_events) begin
                    check("start_bit", 32'(bits[0]), 32'd0);
                    check("stop_bit", 32'(bits[NB-1]), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got byte 0x%02h expected no frame", bits[8:1]);
                    end else begin
                        want = exp_q.pop_front();
                        check("frame_data", 32'(bits[8:1]), 32'(want));
`ifdef MMIO_UART_TX_PARITY_EN
                        check("parity_bit", 32'(bits[9]), 32'(^want));
`endif
                    end
                end
            end
            tx_prev = tx;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        vecs[8];
        logic [31:0] r;
        int          n;
        int          s0;

        vecs[0] = '{1'b0, 1'b1, STAT,          32'd0,         32'h2 | PBIT};
        vecs[1] = '{1'b0, 1'b1, BASE,          32'd0,         32'd0};
        vecs[2] = '{1'b0, 1'b1, BASE + 32'd8,  32'd0,         32'd0};
        vecs[3] = '{1'b0, 1'b1, BASE + 32'd1,  32'd0,         32'd0};
        vecs[4] = '{1'b0, 1'b1, 32'd0,         32'd0,         32'd0};
        vecs[5] = '{1'b1, 1'b0, BASE + 32'h10, 32'h55,        32'd0};
        vecs[6] = '{1'b1, 1'b1, STAT,          32'hFFFF_FFFF, 32'h2 | PBIT};
        vecs[7] = '{1'b0, 1'b1, STAT,          32'd0,         32'h2 | PBIT};

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (50) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_rdata", bus_rdata, 32'd0);
        bus_read(STAT, r);
        check("reset_status", r, 32'h2 | PBIT);

        // Register access table at idle
        for (int i = 0; i < 8; i++) begin
            bus_cycle(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            check($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rdata);
        end
        check("table_idle_busy", 32'(tx_busy), 32'd0);

        // Single byte 0xA5: latency and frame length
        exp_q.push_back(8'hA5);
        bus_cycle(1'b1, 1'b0, BASE, 32'hA5);
        @(negedge clk);
        check("a5_tx_before_pop", 32'(tx), 32'd1);
        check("a5_busy_rise", 32'(tx_busy), 32'd1);
        @(negedge clk);
        check("a5_tx_start", 32'(tx), 32'd0);
        wait_idle(FRAME + 100, n);
        check("a5_busy_len", 32'(n), 32'(FRAME));
        check("a5_drained", 32'(exp_q.size()), 32'd0);
        check("a5_tx_idle", 32'(tx), 32'd1);

        // Three back-to-back bytes with mid-burst STATUS reads
        s0 = starts.size();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h41 + 8'(i));
            bus_cycle(1'b1, 1'b0, BASE, 32'h41 + 32'(i));
        end
        repeat (78) @(negedge clk);
        bus_read(STAT, r);
        check("burst_count2", r, 32'h24 | PBIT);
        @(negedge clk);
        check("rdata_zero_after_read", bus_rdata, 32'd0);
        repeat (157) @(negedge clk);
        bus_read(STAT, r);
        check("burst_count1", r, 32'h14 | PBIT);
        repeat (158) @(negedge clk);
        bus_read(STAT, r);
        check("burst_count0", r, 32'h06 | PBIT);
        wait_idle(3 * FRAME, n);
        check("burst_frames", 32'(starts.size() - s0), 32'd3);
        if (starts.size() - s0 >= 3) begin
            check("burst_gap1", 32'(starts[s0 + 1] - starts[s0]), 32'(FRAME));
            check("burst_gap2", 32'(starts[s0 + 2] - starts[s0 + 1]), 32'(FRAME));
        end
        check("burst_drained", 32'(exp_q.size()), 32'd0);

        // Ten writes into an eight-deep FIFO
        s0 = starts.size();
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'h60 + 8'(i));
            bus_cycle(1'b1, 1'b0, BASE, 32'h60 + 32'(i));
        end
        bus_read(STAT, r);
        check("ovf_status_set", r, 32'h8D | PBIT);
        bus_cycle(1'b1, 1'b1, STAT, 32'h8);
        @(negedge clk);
        check("ovf_clear_readback", bus_rdata, 32'h8D | PBIT);
        bus_read(STAT, r);
        check("ovf_status_cleared", r, 32'h85 | PBIT);
        bus_cycle(1'b1, 1'b0, BASE, 32'hEE);
        bus_read(STAT, r);
        check("ovf_status_reset", r, 32'h8D | PBIT);
        wait_idle(12 * FRAME, n);
        check("ovf_frames", 32'(starts.size() - s0), 32'd9);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);
        bus_read(STAT, r);
        check("ovf_sticky_idle", r, 32'h0A | PBIT);

        // Reset in the middle of the DATA state with three bytes queued
        s0 = starts.size();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h00 + 8'(i * 17));
            bus_cycle(1'b1, 1'b0, BASE, 32'(i * 17));
        end
        repeat (60) @(negedge clk);
        rst_events++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        bus_read(STAT, r);
        check("midrst_status", r, 32'h2 | PBIT);
        repeat (400) @(negedge clk);
        check("midrst_no_frames", 32'(starts.size() - s0), 32'd1);
        check("midrst_tx_idle", 32'(tx), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
